// File: rtl/bp_table_ctrl_if.sv
// Fetch/execute-facing bus of the branch-predictor table controller.
// The master modport belongs to the fetch/execute side, the slave modport to the controller.
interface bp_table_ctrl_if #(
  parameter int IDX_W = 4,
  parameter int DEPTH = 4
) ();
  logic                       req_valid;
  logic [IDX_W-1:0]           req_idx;
  logic                       req_ready;
  logic                       pred_valid;
  logic                       pred_taken;
  logic                       res_valid;
  logic                       res_taken;
  logic                       mispredict;
  logic                       res_err;
  logic [$clog2(DEPTH):0]     outstanding;
  logic [15:0]                stat_total;
  logic [15:0]                stat_miss;

  modport master (
    output req_valid, req_idx, res_valid, res_taken,
    input  req_ready, pred_valid, pred_taken, mispredict, res_err,
           outstanding, stat_total, stat_miss
  );

  modport slave (
    input  req_valid, req_idx, res_valid, res_taken,
    output req_ready, pred_valid, pred_taken, mispredict, res_err,
           outstanding, stat_total, stat_miss
  );
endinterface

// File: rtl/bp_table_ctrl.sv
// 2-bit saturating branch counter table shared by a lookup port and an in-order resolve port.
// Optional statistics counters are built only when BP_STATS_EN is defined.
module bp_table_ctrl #(
  parameter int         IDX_W    = 4,
  parameter int         DEPTH    = 4,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic           clk,
  input  logic           rst,
  bp_table_ctrl_if.slave bus
);
  localparam int ENTRIES = 2 ** IDX_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int OCC_W   = PTR_W + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [1:0]         tbl_q [ENTRIES];
  logic [IDX_W-1:0]   fifo_idx_q  [DEPTH];
  logic               fifo_pred_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               pred_valid_q, pred_taken_q, mispredict_q, res_err_q;

  logic               run, req_ready, push, pop, err_set;
  logic [IDX_W-1:0]   head_idx;
  logic               head_pred, lookup_pred;
  logic               tbl_we;
  logic [IDX_W-1:0]   tbl_wa;
  logic [1:0]         tbl_wd;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
    logic [1:0] res;
    res = cnt;
    if (up && cnt != 2'b11)       res = cnt + 2'b01;
    else if (!up && cnt != 2'b00) res = cnt - 2'b01;
    return res;
  endfunction

  assign run         = (state_q == ST_RUN);
  assign req_ready   = run && (occ_q < OCC_W'(DEPTH));
  assign push        = bus.req_valid && req_ready;
  assign pop         = run && bus.res_valid && (occ_q != '0);
  assign err_set     = run && bus.res_valid && (occ_q == '0);
  assign head_idx    = fifo_idx_q[rd_ptr_q];
  assign head_pred   = fifo_pred_q[rd_ptr_q];
  assign lookup_pred = tbl_q[bus.req_idx][1];

  // The INIT walk and resolve training share the single table write port.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tbl_we  = 1'b0;
    tbl_wa  = '0;
    tbl_wd  = '0;
    case (state_q)
      ST_INIT: begin
        tbl_we = 1'b1;
        tbl_wa = ptr_q;
        tbl_wd = CNT_INIT;
        ptr_d  = ptr_q + 1'b1;
        if (&ptr_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (pop) begin
          tbl_we = 1'b1;
          tbl_wa = head_idx;
          tbl_wd = sat_update(tbl_q[head_idx], bus.res_taken);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      ptr_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      mispredict_q <= 1'b0;
      res_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      occ_q        <= occ_d;
      pred_valid_q <= push;
      pred_taken_q <= push ? lookup_pred : 1'b0;
      mispredict_q <= pop && (bus.res_taken != head_pred);
      if (push)    wr_ptr_q  <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q  <= rd_ptr_q + 1'b1;
      if (err_set) res_err_q <= 1'b1;
    end
  end

  // Table and FIFO payload carry no reset; the INIT walk defines the table contents.
  always_ff @(posedge clk) begin
    if (tbl_we && !rst) tbl_q[tbl_wa] <= tbl_wd;
    if (push && !rst) begin
      fifo_idx_q[wr_ptr_q]  <= bus.req_idx;
      fifo_pred_q[wr_ptr_q] <= lookup_pred;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.pred_valid  = pred_valid_q;
  assign bus.pred_taken  = pred_taken_q;
  assign bus.mispredict  = mispredict_q;
  assign bus.res_err     = res_err_q;
  assign bus.outstanding = occ_q;

`ifdef BP_STATS_EN
  logic [15:0] stat_total_q, stat_miss_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_total_q <= '0;
      stat_miss_q  <= '0;
    end else if (pop) begin
      stat_total_q <= sat_inc(stat_total_q);
      if (bus.res_taken != head_pred) stat_miss_q <= sat_inc(stat_miss_q);
    end
  end

  assign bus.stat_total = stat_total_q;
  assign bus.stat_miss  = stat_miss_q;
`else
  assign bus.stat_total = 16'd0;
  assign bus.stat_miss  = 16'd0;
`endif
endmodule

// File: tb/tb_bp_table_ctrl.sv
// Scoreboard bench for bp_table_ctrl: directed stimulus queues expected results,
// a negedge monitor pops and compares them when the DUT presents its pulses.
module tb_bp_table_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct { int cyc; bit v; } exp_t;
  exp_t pq[$];
  exp_t mq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bp_table_ctrl_if #(.IDX_W(4), .DEPTH(4)) bus ();

  bp_table_ctrl #(.IDX_W(4), .DEPTH(4), .CNT_INIT(2'b01)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pred_valid / mispredict against queued expectations.
  always @(negedge clk) begin
    exp_t e;
    while (pq.size() > 0 && pq[0].cyc < cyc) begin
      e = pq.pop_front();
      checks++; errors++;
      $display("FAIL pred_missing: got none expected pred_valid at cycle %0d", e.cyc);
    end
    while (mq.size() > 0 && mq[0].cyc < cyc) begin
      e = mq.pop_front();
      checks++; errors++;
      $display("FAIL res_missing: got none expected result at cycle %0d", e.cyc);
    end
    if (pq.size() > 0 && pq[0].cyc == cyc) begin
      e = pq.pop_front();
      chk("pred_valid", int'(bus.pred_valid), 1);
      chk("pred_taken", int'(bus.pred_taken), int'(e.v));
    end else if (bus.pred_valid === 1'b1) begin
      checks++; errors++;
      $display("FAIL pred_unexpected: got pred_valid=1 expected 0 (cycle %0d)", cyc);
    end
    if (mq.size() > 0 && mq[0].cyc == cyc) begin
      e = mq.pop_front();
      chk("mispredict", int'(bus.mispredict), int'(e.v));
    end else if (bus.mispredict === 1'b1) begin
      checks++; errors++;
      $display("FAIL mis_unexpected: got mispredict=1 expected 0 (cycle %0d)", cyc);
    end
  end

  // Called at posedge+1; drives one cycle of traffic and queues the expected results.
  task automatic step(input bit rq, input int idx, input bit ep,
                      input bit rs, input bit tk, input bit em);
    bus.req_valid = rq;
    bus.req_idx   = 4'(idx);
    bus.res_valid = rs;
    bus.res_taken = tk;
    if (rq) begin
      chk("req_ready", int'(bus.req_ready), 1);
      pq.push_back('{cyc + 1, ep});
    end
    if (rs) mq.push_back('{cyc + 1, em});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.res_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_idx   = '0;
    bus.res_valid = 1'b0;
    bus.res_taken = 1'b0;

    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_outstanding", int'(bus.outstanding), 0);
    chk("rst_res_err", int'(bus.res_err), 0);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_pred_valid", int'(bus.pred_valid), 0);
    chk("rst_mispredict", int'(bus.mispredict), 0);

    // INIT lasts 16 cycles; resolves during INIT must be ignored.
    bus.res_valid = 1'b1;
    bus.res_taken = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("init_req_ready", int'(bus.req_ready), 0);
    end
    bus.res_valid = 1'b0;
    @(negedge clk);
    chk("run_req_ready", int'(bus.req_ready), 1);
    chk("init_res_err", int'(bus.res_err), 0);
    @(posedge clk); #1;

    // First lookup on idx 5, then saturation at 0.
    step(1, 5, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    // Train idx 3 upward: 1 -> 2 -> 3 -> 3.
    step(1, 3, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1);
    step(1, 3, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(1, 3, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    // idx 5 sits at 0: a not-taken must not wrap.
    step(1, 5, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 5, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1);
    chk("drained_outstanding", int'(bus.outstanding), 0);

    // Fill the FIFO.
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0);
    step(1, 3, 1, 0, 0, 0);
    chk("full_outstanding", int'(bus.outstanding), 4);
    chk("full_req_ready", int'(bus.req_ready), 0);
    // Request while full plus a resolve: request is not accepted this cycle.
    bus.req_valid = 1'b1;
    bus.req_idx   = 4'd7;
    bus.res_valid = 1'b1;
    bus.res_taken = 1'b0;
    mq.push_back('{cyc + 1, 1'b0});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.res_valid = 1'b0;
    chk("after_pop_outstanding", int'(bus.outstanding), 3);
    chk("after_pop_req_ready", int'(bus.req_ready), 1);

    // Resolve idx1 taken (pred 0): mispredict.
    step(0, 0, 0, 1, 1, 1);
    chk("occ2_outstanding", int'(bus.outstanding), 2);
    // Same-cycle lookup and resolve of idx 2: lookup sees old value 1.
    step(1, 2, 0, 1, 1, 1);
    chk("pushpop_outstanding", int'(bus.outstanding), 2);
    // Update applied: idx 2 now 2.
    step(1, 2, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 1, 1, 0);
    chk("empty_outstanding", int'(bus.outstanding), 0);

    // Resolve with nothing outstanding.
    step(0, 0, 0, 1, 1, 0);
    void'(mq.pop_back());
    chk("res_err_set", int'(bus.res_err), 1);
    chk("res_err_outstanding", int'(bus.outstanding), 0);
    step(0, 0, 0, 0, 0, 0);

    // Three outstanding, then reset: no mispredict, everything clears.
    step(1, 4, 0, 0, 0, 0);
    step(1, 4, 0, 0, 0, 0);
    step(1, 4, 0, 0, 0, 0);
    chk("pre_rst_outstanding", int'(bus.outstanding), 3);
    chk("res_err_sticky", int'(bus.res_err), 1);
    rst = 1'b1;
    bus.res_valid = 1'b1;
    bus.res_taken = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.res_valid = 1'b0;
    chk("rst2_outstanding", int'(bus.outstanding), 0);
    chk("rst2_res_err", int'(bus.res_err), 0);
    chk("rst2_req_ready", int'(bus.req_ready), 0);
    chk("rst2_stat_total", int'(bus.stat_total), 0);
    repeat (15) @(posedge clk);
    #1;
    chk("reinit_req_ready", int'(bus.req_ready), 0);
    @(posedge clk); #1;
    chk("rerun_req_ready", int'(bus.req_ready), 1);

    // Table re-walked: idx 3 back to weak not-taken. Five resolves, two wrong.
    step(1, 3, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 6, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1);
    step(1, 6, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(1, 6, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    step(1, 6, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
`ifdef BP_STATS_EN
    chk("stat_total", int'(bus.stat_total), 5);
    chk("stat_miss", int'(bus.stat_miss), 2);
`else
    chk("stat_total_off", int'(bus.stat_total), 0);
    chk("stat_miss_off", int'(bus.stat_miss), 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drain", pq.size() + mq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
